// File: rtl/pll_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer and the blocks around it
// (clock gate, SoC top).
//   - State encodings (PLL_RST..FAULT) and their width SEQ_STATE_W.
//   - Typed state enum built on those encodings.
//   - Default cycle constants used as parameter defaults.
// ----------------------------------------------------------------------------
package pll_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    localparam logic [SEQ_STATE_W-1:0] PLL_RST   = 3'd0;
    localparam logic [SEQ_STATE_W-1:0] WAIT_LOCK = 3'd1;
    localparam logic [SEQ_STATE_W-1:0] STABILISE = 3'd2;
    localparam logic [SEQ_STATE_W-1:0] RUN       = 3'd3;
    localparam logic [SEQ_STATE_W-1:0] FAULT     = 3'd4;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_PLL_RST   = PLL_RST,
        ST_WAIT_LOCK = WAIT_LOCK,
        ST_STABILISE = STABILISE,
        ST_RUN       = RUN,
        ST_FAULT     = FAULT
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 17;

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous level flags.
// Ports:
//   clk     in   1      destination clock
//   resetn  in   1      synchronous active-low reset, clears both stages to 0
//   d       in   WIDTH  asynchronous input flags
//   q       out  WIDTH  synchronised flags (two clk edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Each bit is an independent flag; stages are kept per bit so the
    // structure stays obvious to timing constraints on the meta stage.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (!resetn) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// pll_lock_sequencer
// Sequences PLL start-up and recovery on the reference clock: holds the PLL
// in reset, waits for lock, requires lock to stay stable, then enables the
// output clock gate and (one cycle later) releases the SoC reset. Loss of
// lock or a relock request re-runs the sequence; repeated lock timeouts end
// in a sticky FAULT that only fault_clr (or resetn) leaves.
// Ports:
//   clkin       in   1  reference clock
//   resetn      in   1  synchronous active-low reset
//   pll_locked  in   1  PLL lock flag, asynchronous
//   relock_req  in   1  pulse: force a full re-sequence
//   fault_clr   in   1  pulse: leave FAULT and restart
//   pll_rst     out  1  PLL reset, active high
//   clk_en      out  1  clock gate enable
//   sys_rstn    out  1  SoC reset, active low
//   seq_state   out  3  current state encoding
//   retry_cnt   out  4  failed attempts since last RUN entry
//   fault       out  1  high only in FAULT
// ----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                   clkin,
    input  logic                   resetn,
    input  logic                   pll_locked,
    input  logic                   relock_req,
    input  logic                   fault_clr,
    output logic                   pll_rst,
    output logic                   clk_en,
    output logic                   sys_rstn,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [3:0]             retry_cnt,
    output logic                   fault
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    logic       lk;
    seq_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [3:0] retry_reg, retry_next, retry_inc;
    logic       pll_rst_reg, clk_en_reg, sys_rstn_reg, fault_reg;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk    (clkin),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lk)
    );

    // Both counters saturate instead of wrapping.
    assign cnt_inc   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign retry_inc = (retry_reg >= RETRY_MAX) ? retry_reg : retry_reg + 4'd1;

    // Next-state logic. Branch order inside each state encodes the input
    // priority: relock_req, then lock loss, then counter expiry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_inc;
        retry_next = retry_reg;
        case (state_reg)
            ST_PLL_RST: begin
                if (relock_req) begin
                    cnt_next = '0;
                end else if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (relock_req) begin
                    state_next = ST_PLL_RST;
                end else if (lk) begin
                    // Lock arriving on the timeout cycle still counts as lock.
                    state_next = ST_STABILISE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    state_next = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PLL_RST;
                end
            end
            ST_STABILISE: begin
                if (relock_req) begin
                    state_next = ST_PLL_RST;
                end else if (!lk) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (relock_req || !lk) begin
                    state_next = ST_PLL_RST;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next = ST_PLL_RST;
                    retry_next = 4'd0;
                end
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase
        // cnt measures time in the current state only.
        if (state_next != state_reg) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state_reg    <= ST_PLL_RST;
            cnt_reg      <= '0;
            retry_reg    <= 4'd0;
            pll_rst_reg  <= 1'b1;
            clk_en_reg   <= 1'b0;
            sys_rstn_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            retry_reg    <= retry_next;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself.
            pll_rst_reg  <= (state_next == ST_PLL_RST) || (state_next == ST_FAULT);
            clk_en_reg   <= (state_next == ST_RUN);
            // Only a RUN->RUN stay releases sys_rstn, so the SoC sees at
            // least one gated clock edge while still in reset.
            sys_rstn_reg <= (state_next == ST_RUN) && (state_reg == ST_RUN);
            fault_reg    <= (state_next == ST_FAULT);
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign clk_en    = clk_en_reg;
    assign sys_rstn  = sys_rstn_reg;
    assign seq_state = state_reg;
    assign retry_cnt = retry_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Scoreboard bench: the stimulus process pushes every expected output change
// (cycle stamp + full output tuple) into a queue; the monitor pops and
// compares whenever the DUT's output tuple changes.
// ----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic       clkin = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       relock_req;
    logic       fault_clr;
    logic       pll_rst;
    logic       clk_en;
    logic       sys_rstn;
    logic [2:0] seq_state;
    logic [3:0] retry_cnt;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         stamp;
        logic [2:0] st;
        logic       pr;
        logic       ce;
        logic       sr;
        logic [3:0] rc;
        logic       f;
    } ev_t;

    ev_t         q[$];
    logic [10:0] prev = 'x;

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2),
        .CNT_W               (17)
    ) dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .fault_clr  (fault_clr),
        .pll_rst    (pll_rst),
        .clk_en     (clk_en),
        .sys_rstn   (sys_rstn),
        .seq_state  (seq_state),
        .retry_cnt  (retry_cnt),
        .fault      (fault)
    );

    function automatic void push(input int stamp, input logic [2:0] st, input logic pr,
                                 input logic ce, input logic sr, input logic [3:0] rc,
                                 input logic f);
        ev_t e;
        e.stamp = stamp; e.st = st; e.pr = pr; e.ce = ce; e.sr = sr; e.rc = rc; e.f = f;
        q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Monitor: one line per observed output change.
    always @(negedge clkin) begin
        logic [10:0] cur;
        logic [10:0] exp_v;
        ev_t         e;
        cur = {seq_state, pll_rst, clk_en, sys_rstn, retry_cnt, fault};
        if (q.size() > 0 && q[0].stamp < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d expected st=%0d at cyc=%0d, outputs never changed",
                     cyc, q[0].st, q[0].stamp);
            void'(q.pop_front());
        end
        if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got st=%0d pll_rst=%b clk_en=%b sys_rstn=%b retry=%0d fault=%b, required no change",
                         cyc, seq_state, pll_rst, clk_en, sys_rstn, retry_cnt, fault);
            end else begin
                e     = q.pop_front();
                exp_v = {e.st, e.pr, e.ce, e.sr, e.rc, e.f};
                if (e.stamp != cyc || cur !== exp_v) begin
                    errors++;
                    $display("FAIL event cyc=%0d got st=%0d pll_rst=%b clk_en=%b sys_rstn=%b retry=%0d fault=%b; required cyc=%0d st=%0d pll_rst=%b clk_en=%b sys_rstn=%b retry=%0d fault=%b",
                             cyc, seq_state, pll_rst, clk_en, sys_rstn, retry_cnt, fault,
                             e.stamp, e.st, e.pr, e.ce, e.sr, e.rc, e.f);
                end else begin
                    $display("event cyc=%0d st=%0d pll_rst=%b clk_en=%b sys_rstn=%b retry=%0d fault=%b ok",
                             cyc, seq_state, pll_rst, clk_en, sys_rstn, retry_cnt, fault);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int b, c, d, e, f, h;
        resetn = 1'b0; pll_locked = 1'b1; relock_req = 1'b0; fault_clr = 1'b0;

        // Reset values appear after the first edge.
        push(1, S_RST, 1, 0, 0, 0, 0);
        tick(3);

        // 1: clean start with lock already present.
        resetn = 1'b1; b = cyc;
        push(b + 4,  S_WAIT, 0, 0, 0, 0, 0);
        push(b + 5,  S_STAB, 0, 0, 0, 0, 0);
        push(b + 13, S_RUN,  0, 1, 0, 0, 0);
        push(b + 14, S_RUN,  0, 1, 1, 0, 0);
        tick(20);

        // 4: lock loss in RUN, then 2: one-cycle lk glitch at STABILISE cnt=5.
        c = cyc; pll_locked = 1'b0;
        push(c + 3, S_RST,  1, 0, 0, 0, 0);
        push(c + 7, S_WAIT, 0, 0, 0, 0, 0);
        tick(7);
        d = cyc; pll_locked = 1'b1;
        push(d + 3, S_STAB, 0, 0, 0, 0, 0);
        tick(6); pll_locked = 1'b0;
        tick(1); pll_locked = 1'b1;
        push(d + 9,  S_WAIT, 0, 0, 0, 0, 0);
        push(d + 10, S_STAB, 0, 0, 0, 0, 0);
        push(d + 18, S_RUN,  0, 1, 0, 0, 0);
        push(d + 19, S_RUN,  0, 1, 1, 0, 0);
        tick(15);

        // 5: relock_req in RUN, then again in PLL_RST at cnt=2 (cnt restarts).
        e = cyc; relock_req = 1'b1;
        push(e + 1, S_RST, 1, 0, 0, 0, 0);
        tick(1); relock_req = 1'b0;
        tick(2); relock_req = 1'b1;
        tick(1); relock_req = 1'b0;
        push(e + 8,  S_WAIT, 0, 0, 0, 0, 0);
        push(e + 9,  S_STAB, 0, 0, 0, 0, 0);
        push(e + 17, S_RUN,  0, 1, 0, 0, 0);
        push(e + 18, S_RUN,  0, 1, 1, 0, 0);
        tick(17);

        // 3: lock never returns -> two timeouts -> FAULT.
        f = cyc; pll_locked = 1'b0;
        push(f + 3,  S_RST,   1, 0, 0, 0, 0);
        push(f + 7,  S_WAIT,  0, 0, 0, 0, 0);
        push(f + 27, S_RST,   1, 0, 0, 1, 0);
        push(f + 31, S_WAIT,  0, 0, 0, 1, 0);
        push(f + 51, S_FAULT, 1, 0, 0, 2, 1);
        tick(53);

        // relock_req in FAULT must change nothing.
        relock_req = 1'b1;
        tick(1); relock_req = 1'b0;
        tick(4);

        // fault_clr restarts with retry_cnt=0.
        h = cyc; fault_clr = 1'b1;
        push(h + 1, S_RST,  1, 0, 0, 0, 0);
        tick(1); fault_clr = 1'b0;
        push(h + 5, S_WAIT, 0, 0, 0, 0, 0);
        tick(21);

        // lk rises exactly on the timeout cycle (WAIT cnt=19): lock wins.
        pll_locked = 1'b1;
        push(h + 25, S_STAB, 0, 0, 0, 0, 0);
        tick(5);

        // resetn in STABILISE -> reset values on the next edge, then restart.
        resetn = 1'b0;
        push(h + 28, S_RST, 1, 0, 0, 0, 0);
        tick(1);
        resetn = 1'b1;
        push(h + 32, S_WAIT, 0, 0, 0, 0, 0);
        push(h + 33, S_STAB, 0, 0, 0, 0, 0);
        push(h + 41, S_RUN,  0, 1, 0, 0, 0);
        push(h + 42, S_RUN,  0, 1, 1, 0, 0);
        tick(16);

        // Bounded drain of any remaining expected events.
        for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
